// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command-bus arbiter: init first, then one-at-a-time grants to refresh/write/read.
// Round-robin between write and read, refresh has priority, and a stuck owner is forcibly released.
module sdram_arbit #(
  parameter int          GRANT_TIMEOUT = 1024,
  parameter int          CNT_W         = 16,
  parameter logic [3:0]  NOP           = 4'b0111
) (
  input  logic        s_clk,
  input  logic        s_rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        init_end,
  input  logic        req_aref,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        aref_end,
  output logic        en_aref,
  input  logic        req_wr,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        wr_end,
  output logic        en_wr,
  input  logic        req_rd,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  input  logic        rd_end,
  output logic        en_rd,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        arb_timeout,
  output logic        arb_err
);

  typedef enum logic [4:0] {
    ARB_INIT  = 5'b00001,
    ARB_IDLE  = 5'b00010,
    ARB_AREF  = 5'b00100,
    ARB_WRITE = 5'b01000,
    ARB_READ  = 5'b10000
  } arb_state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(GRANT_TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic             last_rd_q, last_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cke_q, cke_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic             grant_act;
  logic             grant_end;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= ARB_INIT;
      last_rd_q <= 1'b1;
      cnt_q     <= '0;
      cke_q     <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      cke_q     <= cke_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    cnt_d     = cnt_q;
    cke_d     = 1'b1;
    timeout_d = 1'b0;
    err_d     = err_q;
    grant_act = 1'b0;
    grant_end = 1'b0;
    case (state_q)
      ARB_INIT: begin
        if (init_end) state_d = ARB_IDLE;
      end
      ARB_IDLE: begin
        cnt_d = '0;
        // On a wr/rd conflict, write wins only when read went last.
        if (req_aref) begin
          state_d = ARB_AREF;
        end else if (req_wr && (!req_rd || last_rd_q)) begin
          state_d   = ARB_WRITE;
          last_rd_d = 1'b0;
        end else if (req_rd) begin
          state_d   = ARB_READ;
          last_rd_d = 1'b1;
        end
      end
      ARB_AREF: begin
        grant_act = 1'b1;
        grant_end = aref_end;
      end
      ARB_WRITE: begin
        grant_act = 1'b1;
        grant_end = wr_end;
      end
      ARB_READ: begin
        grant_act = 1'b1;
        grant_end = rd_end;
      end
      default: state_d = ARB_IDLE;
    endcase

    // A real end in the final cycle is a clean exit, not a timeout.
    if (grant_act) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (grant_end) begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == TIMEOUT_CNT) begin
        state_d   = ARB_IDLE;
        cnt_d     = '0;
        timeout_d = 1'b1;
        err_d     = 1'b1;
      end
    end
  end

  always_comb begin
    sdram_cmd  = NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    case (state_q)
      ARB_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ARB_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ARB_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      ARB_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

  assign en_aref     = (state_q == ARB_AREF);
  assign en_wr       = (state_q == ARB_WRITE);
  assign en_rd       = (state_q == ARB_READ);
  assign sdram_cke   = cke_q;
  assign arb_timeout = timeout_q;
  assign arb_err     = err_q;

endmodule
